// File: rtl/pwm_param_loader_pkg.sv
// Shared constants for the PWM parameter loader: register map,
// CTRL/STATUS bit positions and the load sequencer state encoding.
package pwm_param_loader_pkg;

    // Register map (3-bit address space)
    localparam logic [2:0] ADDR_FREQ_LO = 3'd0;
    localparam logic [2:0] ADDR_FREQ_HI = 3'd1;
    localparam logic [2:0] ADDR_DUTY_LO = 3'd2;
    localparam logic [2:0] ADDR_DUTY_HI = 3'd3;
    localparam logic [2:0] ADDR_CTRL    = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd5;

    // CTRL bits: enable is stored, commit and clear-error are one-shot
    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_COMMIT_BIT  = 1;
    localparam int CTRL_CLR_ERR_BIT = 2;

    // STATUS bits
    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_ERR_BIT    = 1;
    localparam int STAT_ENABLE_BIT = 2;

    // Load sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } ld_state_t;

endpackage

// File: rtl/pwm_param_loader.sv
// DSP-facing register block that stages PWM period/duty in shadow
// registers and transfers them to the generator under a pwm_reset hold.
module pwm_param_loader
    import pwm_param_loader_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic        xclk,
    input  logic        reset,
    input  logic        wr_strobe,
    input  logic        rd_strobe,
    input  logic [2:0]  addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic [31:0] stored_pwm_freq,
    output logic [31:0] stored_pwm_dty_cycl,
    output logic        pwm_reset,
    output logic        busy
);

    // HOLD lasts HOLD_CYCLES-1 cycles; LOAD adds the last low cycle.
    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 2);

    ld_state_t   state;
    ld_state_t   state_nxt;
    logic [7:0]  hold_cnt;
    logic [15:0] freq_lo;
    logic [15:0] freq_hi;
    logic [15:0] duty_lo;
    logic [15:0] duty_hi;
    logic [31:0] shadow_freq;
    logic [31:0] shadow_duty;
    logic        enable;
    logic        cfg_err;
    logic        ctrl_wr;
    logic        commit_req;
    logic        cfg_valid;
    logic        commit_reject;
    logic [15:0] status_word;
    logic [15:0] rd_mux;

    assign shadow_freq = {freq_hi, freq_lo};
    assign shadow_duty = {duty_hi, duty_lo};
    assign ctrl_wr     = wr_strobe && (addr == ADDR_CTRL);
    assign commit_req  = ctrl_wr && wr_data[CTRL_COMMIT_BIT];
    assign cfg_valid   = (shadow_freq != 32'd0) && (shadow_duty <= shadow_freq);

    // Sequencer state register
    always_ff @(posedge xclk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and generator-facing outputs
    always_comb begin
        state_nxt     = state;
        commit_reject = 1'b0;
        busy          = 1'b1;
        pwm_reset     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                pwm_reset = enable;
                if (commit_req) begin
                    if (cfg_valid) state_nxt     = ST_HOLD;
                    else           commit_reject = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == 8'd0) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                pwm_reset = enable;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Hold timer: preloaded outside HOLD, counts down to zero inside it
    always_ff @(posedge xclk) begin
        if (reset || state != ST_HOLD) hold_cnt <= HOLD_INIT;
        else if (hold_cnt != 8'd0)     hold_cnt <= hold_cnt - 8'd1;
    end

    // Shadow registers accept DSP writes in every state
    always_ff @(posedge xclk) begin
        if (reset) begin
            freq_lo <= '0;
            freq_hi <= '0;
            duty_lo <= '0;
            duty_hi <= '0;
        end else if (wr_strobe) begin
            case (addr)
                ADDR_FREQ_LO: freq_lo <= wr_data;
                ADDR_FREQ_HI: freq_hi <= wr_data;
                ADDR_DUTY_LO: duty_lo <= wr_data;
                ADDR_DUTY_HI: duty_hi <= wr_data;
                default: ;
            endcase
        end
    end

    // Enable and sticky error; a failing commit wins over a same-write clear
    always_ff @(posedge xclk) begin
        if (reset) begin
            enable  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            if (ctrl_wr) enable <= wr_data[CTRL_ENABLE_BIT];
            if (commit_reject)                            cfg_err <= 1'b1;
            else if (ctrl_wr && wr_data[CTRL_CLR_ERR_BIT]) cfg_err <= 1'b0;
        end
    end

    // Active parameters change only on the LOAD cycle, from pre-write shadow
    always_ff @(posedge xclk) begin
        if (reset) begin
            stored_pwm_freq     <= '0;
            stored_pwm_dty_cycl <= '0;
        end else if (state == ST_LOAD) begin
            stored_pwm_freq     <= shadow_freq;
            stored_pwm_dty_cycl <= shadow_duty;
        end
    end

    // Read-back source selection
    always_comb begin
        status_word                  = '0;
        status_word[STAT_BUSY_BIT]   = busy;
        status_word[STAT_ERR_BIT]    = cfg_err;
        status_word[STAT_ENABLE_BIT] = enable;
        case (addr)
            ADDR_FREQ_LO: rd_mux = freq_lo;
            ADDR_FREQ_HI: rd_mux = freq_hi;
            ADDR_DUTY_LO: rd_mux = duty_lo;
            ADDR_DUTY_HI: rd_mux = duty_hi;
            ADDR_STATUS:  rd_mux = status_word;
            default:      rd_mux = 16'h0000;
        endcase
    end

    // Read data register, held between reads
    always_ff @(posedge xclk) begin
        if (reset)          rd_data <= '0;
        else if (rd_strobe) rd_data <= rd_mux;
    end

endmodule

// File: tb/tb_pwm_param_loader.sv
// Directed bench for pwm_param_loader: register access table plus
// hand-written load, reject, collision and reset sequences.
`timescale 1ns/1ps
module tb_pwm_param_loader;

    logic        xclk = 1'b0;
    logic        reset;
    logic        wr_strobe;
    logic        rd_strobe;
    logic [2:0]  addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic [31:0] stored_pwm_freq;
    logic [31:0] stored_pwm_dty_cycl;
    logic        pwm_reset;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_wr;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[15];

    pwm_param_loader #(.HOLD_CYCLES(4)) dut (
        .xclk                (xclk),
        .reset               (reset),
        .wr_strobe           (wr_strobe),
        .rd_strobe           (rd_strobe),
        .addr                (addr),
        .wr_data             (wr_data),
        .rd_data             (rd_data),
        .stored_pwm_freq     (stored_pwm_freq),
        .stored_pwm_dty_cycl (stored_pwm_dty_cycl),
        .pwm_reset           (pwm_reset),
        .busy                (busy)
    );

    always #6.667 xclk = ~xclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the write edge
    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        wr_strobe = 1'b1;
        addr      = a;
        wr_data   = d;
        @(negedge xclk);
        wr_strobe = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a);
        rd_strobe = 1'b1;
        addr      = a;
        @(negedge xclk);
        rd_strobe = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [15:0] exp);
        read_reg(a);
        check(name, {16'h0, rd_data}, {16'h0, exp});
    endtask

    initial begin
        int busy_cnt;
        int low_cnt;
        logic saw_busy;
        logic saw_low;

        vecs[0]  = '{1'b0, 3'd0, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 3'd1, 16'h1234, 16'h0000};
        vecs[2]  = '{1'b0, 3'd1, 16'h0000, 16'h1234};
        vecs[3]  = '{1'b0, 3'd6, 16'h0000, 16'h0000};
        vecs[4]  = '{1'b1, 3'd0, 16'hBEEF, 16'h0000};
        vecs[5]  = '{1'b0, 3'd0, 16'h0000, 16'hBEEF};
        vecs[6]  = '{1'b1, 3'd2, 16'h00AA, 16'hBEEF};
        vecs[7]  = '{1'b1, 3'd3, 16'h5555, 16'hBEEF};
        vecs[8]  = '{1'b0, 3'd3, 16'h0000, 16'h5555};
        vecs[9]  = '{1'b0, 3'd2, 16'h0000, 16'h00AA};
        vecs[10] = '{1'b0, 3'd4, 16'h0000, 16'h0000};
        vecs[11] = '{1'b0, 3'd7, 16'h0000, 16'h0000};
        vecs[12] = '{1'b0, 3'd5, 16'h0000, 16'h0000};
        vecs[13] = '{1'b0, 3'd1, 16'h0000, 16'h1234};
        vecs[14] = '{1'b1, 3'd6, 16'hFFFF, 16'h1234};

        reset     = 1'b1;
        wr_strobe = 1'b0;
        rd_strobe = 1'b0;
        addr      = 3'd0;
        wr_data   = 16'h0;
        repeat (3) @(negedge xclk);
        check("reset_freq",  stored_pwm_freq, 32'h0);
        check("reset_duty",  stored_pwm_dty_cycl, 32'h0);
        check("reset_pwmrst", {31'h0, pwm_reset}, 32'h0);
        check("reset_busy",  {31'h0, busy}, 32'h0);
        check("reset_rd",    {16'h0, rd_data}, 32'h0);
        reset = 1'b0;
        @(negedge xclk);

        // Register access table; rd_data checked after every op
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_wr) write_reg(vecs[i].addr, vecs[i].data);
            else               read_reg(vecs[i].addr);
            check($sformatf("vec%0d_rd", i), {16'h0, rd_data}, {16'h0, vecs[i].exp_rd});
        end
        check("shadow_isolated_freq", stored_pwm_freq, 32'h0);
        check("shadow_isolated_duty", stored_pwm_dty_cycl, 32'h0);

        // Normal load: freq 0x64, duty 0x32, enable+commit
        write_reg(3'd0, 16'h0064);
        write_reg(3'd1, 16'h0000);
        write_reg(3'd2, 16'h0032);
        write_reg(3'd3, 16'h0000);
        check("pre_load_pwmrst", {31'h0, pwm_reset}, 32'h0);
        write_reg(3'd4, 16'h0003);
        busy_cnt = 0;
        low_cnt  = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy) busy_cnt++;
            if (!pwm_reset) low_cnt++;
            if (k == 3) check("load_cycle_freq_old", stored_pwm_freq, 32'h0);
            if (k == 4) begin
                check("release_freq", stored_pwm_freq, 32'h64);
                check("release_pwmrst", {31'h0, pwm_reset}, 32'h1);
            end
            @(negedge xclk);
        end
        check("load_busy_cycles", busy_cnt, 5);
        check("load_low_cycles", low_cnt, 4);
        check("load_duty", stored_pwm_dty_cycl, 32'h32);
        check("after_load_pwmrst", {31'h0, pwm_reset}, 32'h1);
        read_check("status_after_load", 3'd5, 16'h0004);

        // Rejected commit: duty 0x65 > freq 0x64
        write_reg(3'd2, 16'h0065);
        write_reg(3'd4, 16'h0003);
        saw_busy = 1'b0;
        saw_low  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (busy) saw_busy = 1'b1;
            if (!pwm_reset) saw_low = 1'b1;
            @(negedge xclk);
        end
        check("reject_no_busy", {31'h0, saw_busy}, 32'h0);
        check("reject_no_drop", {31'h0, saw_low}, 32'h0);
        read_check("reject_status", 3'd5, 16'h0006);
        check("reject_freq_kept", stored_pwm_freq, 32'h64);
        check("reject_duty_kept", stored_pwm_dty_cycl, 32'h32);

        // freq=0 with commit+clear in one write keeps the error set
        write_reg(3'd0, 16'h0000);
        write_reg(3'd4, 16'h0007);
        read_check("zero_freq_status", 3'd5, 16'h0006);
        write_reg(3'd4, 16'h0004);
        read_check("clear_err_status", 3'd5, 16'h0000);
        check("disabled_pwmrst", {31'h0, pwm_reset}, 32'h0);
        write_reg(3'd4, 16'h0001);
        check("enable_pwmrst", {31'h0, pwm_reset}, 32'h1);

        // Second commit during HOLD is ignored; duty == freq is legal
        write_reg(3'd0, 16'h00C8);
        write_reg(3'd2, 16'h00C8);
        write_reg(3'd4, 16'h0003);
        busy_cnt = busy ? 1 : 0;
        write_reg(3'd4, 16'h0003);
        for (int k = 0; k < 10; k++) begin
            if (busy) busy_cnt++;
            @(negedge xclk);
        end
        check("double_commit_busy", busy_cnt, 5);
        check("double_commit_freq", stored_pwm_freq, 32'hC8);
        check("double_commit_duty", stored_pwm_dty_cycl, 32'hC8);
        read_check("double_commit_status", 3'd5, 16'h0004);

        // Shadow write during LOAD does not disturb the loaded value
        write_reg(3'd0, 16'h0050);
        write_reg(3'd2, 16'h0020);
        write_reg(3'd4, 16'h0003);
        repeat (3) @(negedge xclk);
        check("in_load_busy", {31'h0, busy}, 32'h1);
        check("in_load_pwmrst", {31'h0, pwm_reset}, 32'h0);
        write_reg(3'd0, 16'h0040);
        check("collide_freq", stored_pwm_freq, 32'h50);
        check("collide_duty", stored_pwm_dty_cycl, 32'h20);
        repeat (2) @(negedge xclk);
        read_check("collide_shadow", 3'd0, 16'h0040);

        // Reset during HOLD aborts the load
        write_reg(3'd4, 16'h0003);
        check("abort_busy_before", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge xclk);
        check("abort_freq", stored_pwm_freq, 32'h0);
        check("abort_duty", stored_pwm_dty_cycl, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_pwmrst", {31'h0, pwm_reset}, 32'h0);
        check("abort_rd", {16'h0, rd_data}, 32'h0);
        reset = 1'b0;
        @(negedge xclk);
        read_check("abort_freq_lo", 3'd0, 16'h0000);
        read_check("abort_status", 3'd5, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_param_loader.md
PWM_PARAM_LOADER -- requirements
Module: pwm_param_loader

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, meaning the number of xclk cycles pwm_reset is held low around a parameter load (legal range 2..255).
REQ-002 SHALL have port xclk, input, 1 bit: the single 75 MHz clock for all logic.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port wr_strobe, input, 1 bit: DSP write qualifier, one xclk cycle per write.
REQ-005 SHALL have port rd_strobe, input, 1 bit: DSP read qualifier, one xclk cycle per read.
REQ-006 SHALL have port addr, input, 3 bits: register select.
REQ-007 SHALL have port wr_data, input, 16 bits: DSP write data.
REQ-008 SHALL have port rd_data, output, 16 bits: DSP read data.
REQ-009 SHALL have port stored_pwm_freq, output, 32 bits: active period count driven to the PWM generator.
REQ-010 SHALL have port stored_pwm_dty_cycl, output, 32 bits: active duty count driven to the PWM generator.
REQ-011 SHALL have port pwm_reset, output, 1 bit: active-low hold to the PWM generator.
REQ-012 SHALL have port busy, output, 1 bit: high while a load sequence is in progress.

Function
REQ-013 SHALL decode the register map as: 0 FREQ_LO, 1 FREQ_HI, 2 DUTY_LO, 3 DUTY_HI (shadow, R/W); 4 CTRL (W); 5 STATUS (R); 6-7 reserved.
REQ-014 SHALL define CTRL as: bit0 enable (stored); bit1 commit (self-clearing pulse); bit2 clear cfg_err (self-clearing pulse).
REQ-015 SHALL define STATUS as {13'b0, enable, cfg_err, busy}.
REQ-016 SHALL accept shadow writes in every state; shadow contents never reach the outputs except through LOAD.
REQ-017 SHALL register rd_data one cycle after rd_strobe, returning shadow halves for addresses 0-3, STATUS for 5, and 16'h0000 for 4, 6 and 7; rd_data holds its value between reads.
REQ-018 SHALL run a state machine with states IDLE, HOLD, LOAD and RELEASE.
REQ-019 In IDLE, on commit with shadow freq != 0 and shadow duty <= shadow freq, the FSM SHALL go to HOLD on the next cycle; otherwise it SHALL set sticky cfg_err and stay in IDLE.
REQ-020 In HOLD, the FSM SHALL drive pwm_reset=0 for HOLD_CYCLES-1 cycles and then go to LOAD.
REQ-021 In LOAD, the FSM SHALL copy the shadow registers to stored_pwm_freq and stored_pwm_dty_cycl in one cycle, keep pwm_reset=0, and go to RELEASE.
REQ-022 In RELEASE, pwm_reset SHALL equal enable, and the FSM SHALL return to IDLE after one cycle.
REQ-023 busy SHALL be high in HOLD, LOAD and RELEASE, so a load takes HOLD_CYCLES+1 busy cycles.
REQ-024 SHALL ignore a commit received while busy, with no state change and no error set.
REQ-025 In IDLE, pwm_reset SHALL equal enable, taking effect on the cycle after the CTRL write.
REQ-026 A single CTRL write with commit=1 and clear-error=1 SHALL clear cfg_err before validation, so a failed commit leaves cfg_err=1.
REQ-027 A shadow write on the same cycle the FSM is in LOAD SHALL not alter the loaded values (LOAD samples pre-write shadow).
REQ-028 stored_pwm_freq and stored_pwm_dty_cycl SHALL change only in LOAD and remain glitch-free registered outputs.

Reset
REQ-029 On reset: all shadow registers = 0, stored_pwm_freq = 0, stored_pwm_dty_cycl = 0, enable = 0, cfg_err = 0, FSM = IDLE, pwm_reset = 0, busy = 0, rd_data = 0.
REQ-030 Reset asserted mid-sequence SHALL abort the load at the next xclk edge, leaving the outputs at their reset values.

Structure
REQ-031 A shared package SHALL hold the register address constants, the CTRL/STATUS bit positions, and the FSM state encoding.
REQ-032 The hold timer SHALL be an 8-bit down-counter inside the module; no sub-module is required.

Verification
REQ-033 Write FREQ=0x00000064 and DUTY=0x00000032, enable=1, commit -> pwm_reset low for 4 cycles, outputs update in LOAD, busy high for 5 cycles, then pwm_reset=1.
REQ-034 Commit with DUTY=0x65 and FREQ=0x64 -> cfg_err=1, outputs unchanged, pwm_reset never drops.
REQ-035 Commit with FREQ=0 -> cfg_err=1; a subsequent CTRL write of 0x4 -> STATUS bit1 reads 0.
REQ-036 Second commit during HOLD -> ignored, only one load sequence occurs, and the values are those latched at the first LOAD.
REQ-037 Assert reset during HOLD -> next cycle all outputs are 0 and busy=0; read FREQ_LO -> 0x0000.
REQ-038 Write FREQ_HI=0x1234, read addr 1 -> rd_data=0x1234 one cycle after rd_strobe; read addr 6 -> 0x0000.
